// File: rtl/ccip_tx_protocol_monitor.sv
// ccip_tx_protocol_monitor: CCI-P TX almost-full overrun and low-address write monitor.
// Rev 1.0 - initial release.
`default_nettype none

module ccip_tx_protocol_monitor #(
  parameter int                N_CH             = 2,
  parameter int                MAX_ALMFULL_PKTS = 8,
  parameter int                CNT_W            = 32,
  parameter int                ADDR_W           = 42,
  parameter logic [ADDR_W-1:0] ADDR_FLOOR       = 'h100
) (
  input  logic                  pClk,
  input  logic                  pck_cp2af_softReset,
  input  logic [N_CH-1:0]       almfull,
  input  logic [N_CH-1:0]       tx_valid,
  input  logic                  wr_valid,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic                  clear_errs,
  output logic [N_CH*CNT_W-1:0] almfull_cnt,
  output logic [N_CH*CNT_W-1:0] peak_cnt,
  output logic [N_CH-1:0]       err_almfull,
  output logic                  err_addr,
  output logic                  err_any,
  output logic                  first_err_valid,
  output logic [3:0]            first_err_code,
  output logic [ADDR_W-1:0]     bad_addr,
  output logic [CNT_W-1:0]      viol_total
);

  localparam logic [CNT_W:0] c_MAX_PKTS = (CNT_W+1)'(MAX_ALMFULL_PKTS);

  logic [CNT_W-1:0]  count_q [N_CH];
  logic [CNT_W-1:0]  count_d [N_CH];
  logic [CNT_W-1:0]  peak_q  [N_CH];
  logic [CNT_W-1:0]  peak_d  [N_CH];
  logic [CNT_W-1:0]  peak_base;
  logic [N_CH-1:0]   ovr;
  logic              addr_ev;
  logic [N_CH-1:0]   err_af_q, err_af_d;
  logic              err_addr_q, err_addr_d;
  logic              err_any_q;
  logic              fv_q, fv_d;
  logic [3:0]        code_q, code_d;
  logic [ADDR_W-1:0] bad_q, bad_d;
  logic [3:0]        n_ev;
  logic [CNT_W:0]    viol_sum;
  logic [CNT_W-1:0]  viol_q, viol_d;

  always_comb begin
    ovr       = '0;
    n_ev      = '0;
    peak_base = '0;
    for (int i = 0; i < N_CH; i++) begin
      count_d[i] = count_q[i];
      if (!almfull[i]) begin
        count_d[i] = '0;
      end else if (tx_valid[i]) begin
        if (count_q[i] != '1) count_d[i] = count_q[i] + 1'b1;
        // Compare the pre-increment count: the (MAX+1)th packet is the overrun.
        if ({1'b0, count_q[i]} >= c_MAX_PKTS) ovr[i] = 1'b1;
      end
      peak_base = clear_errs ? count_q[i] : peak_q[i];
      peak_d[i] = (count_d[i] > peak_base) ? count_d[i] : peak_base;
      n_ev      = n_ev + {3'b000, ovr[i]};
    end

    addr_ev    = wr_valid && (wr_addr <= ADDR_FLOOR);
    n_ev       = n_ev + {3'b000, addr_ev};
    err_af_d   = (clear_errs ? '0 : err_af_q) | ovr;
    err_addr_d = (clear_errs ? 1'b0 : err_addr_q) | addr_ev;

    // Clearing only rearms capture; code and address keep their last value.
    fv_d   = fv_q && !clear_errs;
    code_d = code_q;
    bad_d  = bad_q;
    if ((!fv_q || clear_errs) && ((|ovr) || addr_ev)) begin
      fv_d   = 1'b1;
      code_d = 4'hF;
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (ovr[i]) code_d = 4'(i);
      end
      if (!(|ovr)) bad_d = wr_addr;
    end

    viol_sum = {1'b0, viol_q} + {{(CNT_W-3){1'b0}}, n_ev};
    viol_d   = viol_sum[CNT_W] ? '1 : viol_sum[CNT_W-1:0];
  end

  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      for (int i = 0; i < N_CH; i++) begin
        count_q[i] <= '0;
        peak_q[i]  <= '0;
      end
      err_af_q   <= '0;
      err_addr_q <= 1'b0;
      err_any_q  <= 1'b0;
      fv_q       <= 1'b0;
      code_q     <= '0;
      bad_q      <= '0;
      viol_q     <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        count_q[i] <= count_d[i];
        peak_q[i]  <= peak_d[i];
      end
      err_af_q   <= err_af_d;
      err_addr_q <= err_addr_d;
      err_any_q  <= (|err_af_d) || err_addr_d;
      fv_q       <= fv_d;
      code_q     <= code_d;
      bad_q      <= bad_d;
      viol_q     <= viol_d;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_pack
    assign almfull_cnt[gi*CNT_W +: CNT_W] = count_q[gi];
    assign peak_cnt[gi*CNT_W +: CNT_W]    = peak_q[gi];
  end

  assign err_almfull     = err_af_q;
  assign err_addr        = err_addr_q;
  assign err_any         = err_any_q;
  assign first_err_valid = fv_q;
  assign first_err_code  = code_q;
  assign bad_addr        = bad_q;
  assign viol_total      = viol_q;

endmodule

`default_nettype wire

// File: tb/tb_ccip_tx_protocol_monitor.sv
// tb_ccip_tx_protocol_monitor: table-driven directed check of the TX protocol monitor.
// Rev 1.0 - initial release.
`default_nettype none

module tb_ccip_tx_protocol_monitor;

  localparam int N_CH   = 2;
  localparam int CNT_W  = 4;
  localparam int ADDR_W = 42;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       almfull, tx_valid;
  logic                  wr_valid, clear_errs;
  logic [ADDR_W-1:0]     wr_addr;
  logic [N_CH*CNT_W-1:0] almfull_cnt, peak_cnt;
  logic [N_CH-1:0]       err_almfull;
  logic                  err_addr, err_any, first_err_valid;
  logic [3:0]            first_err_code;
  logic [ADDR_W-1:0]     bad_addr;
  logic [CNT_W-1:0]      viol_total;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ccip_tx_protocol_monitor #(
    .N_CH(N_CH), .MAX_ALMFULL_PKTS(8), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .ADDR_FLOOR('h100)
  ) u_dut (
    .pClk(clk), .pck_cp2af_softReset(rst), .almfull(almfull), .tx_valid(tx_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .clear_errs(clear_errs),
    .almfull_cnt(almfull_cnt), .peak_cnt(peak_cnt), .err_almfull(err_almfull),
    .err_addr(err_addr), .err_any(err_any), .first_err_valid(first_err_valid),
    .first_err_code(first_err_code), .bad_addr(bad_addr), .viol_total(viol_total)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  af, tv;
    logic        wv;
    logic [41:0] wa;
    logic        clr;
    logic [3:0]  c0, c1, p0, p1;
    logic [1:0]  eaf;
    logic        ea, fv;
    logic [3:0]  code;
    logic [41:0] bad;
    logic [3:0]  viol;
    logic        chk_cap;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic r, logic [1:0] af, logic [1:0] tv, logic wv,
                              logic [41:0] wa, logic clr, int c0, int c1, int p0, int p1,
                              logic [1:0] eaf, logic ea, logic fv, logic [3:0] code,
                              logic [41:0] bad, int viol, logic chk_cap);
    vec_t v;
    v.rst = r; v.af = af; v.tv = tv; v.wv = wv; v.wa = wa; v.clr = clr;
    v.c0 = 4'(c0); v.c1 = 4'(c1); v.p0 = 4'(p0); v.p1 = 4'(p1);
    v.eaf = eaf; v.ea = ea; v.fv = fv; v.code = code; v.bad = bad;
    v.viol = 4'(viol); v.chk_cap = chk_cap;
    vq.push_back(v);
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step(logic r, logic [1:0] af, logic [1:0] tv, logic wv,
                      logic [41:0] wa, logic clr);
    rst = r; almfull = af; tx_valid = tv; wr_valid = wv; wr_addr = wa; clear_errs = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; almfull = '0; tx_valid = '0; wr_valid = 1'b0; wr_addr = '0; clear_errs = 1'b0;

    // Reset state
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 4'h0, 0, 0, 1);
    // Eight packets under almfull on ch0, then the overrun on the ninth
    for (int k = 1; k <= 8; k++) add(0, 1, 1, 0, 0, 0, k, 0, k, 0, 0, 0, 0, 4'h0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0,  9, 0, 9, 0,  2'b01, 0, 1, 4'h0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0,  9, 0, 9, 0,  2'b01, 0, 1, 4'h0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0,  0, 0, 9, 0,  2'b01, 0, 1, 4'h0, 0, 1, 1);
    // Two bursts of five on ch1 separated by a one-cycle almfull drop
    for (int k = 1; k <= 5; k++) add(0, 2, 2, 0, 0, 0, 0, k, 9, k, 2'b01, 0, 1, 4'h0, 0, 1, 1);
    add(0, 0, 2, 0, 0, 0,  0, 0, 9, 5,  2'b01, 0, 1, 4'h0, 0, 1, 1);
    for (int k = 1; k <= 5; k++) add(0, 2, 2, 0, 0, 0, 0, k, 9, 5, 2'b01, 0, 1, 4'h0, 0, 1, 1);
    // Clear reloads peaks with live counts and leaves counts and viol_total alone
    add(0, 2, 0, 0, 0, 1,  0, 5, 0, 5,  2'b00, 0, 0, 4'h0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 5,  2'b00, 0, 0, 4'h0, 0, 1, 0);
    // Address at the floor is illegal; one above is legal
    add(0, 0, 0, 1, 42'h100, 0,  0, 0, 0, 5,  2'b00, 1, 1, 4'hF, 42'h100, 2, 1);
    add(0, 0, 0, 0, 0, 1,        0, 0, 0, 0,  2'b00, 0, 0, 4'hF, 42'h100, 2, 0);
    add(0, 0, 0, 1, 42'h101, 0,  0, 0, 0, 0,  2'b00, 0, 0, 4'hF, 42'h100, 2, 0);
    // Simultaneous overruns on both channels plus a bad address
    for (int k = 1; k <= 8; k++) add(0, 3, 3, 0, 0, 0, k, k, k, k, 2'b00, 0, 0, 4'h0, 0, 2, 0);
    add(0, 3, 3, 1, 42'h50, 0,  9, 9, 9, 9,  2'b11, 1, 1, 4'h0, 42'h100, 5, 1);
    // Clear coincident with the tenth ch0 packet: event wins and is recaptured
    add(0, 3, 1, 0, 0, 1,  10, 9, 10, 9,  2'b01, 0, 1, 4'h0, 42'h100, 6, 1);

    foreach (vq[n]) begin
      vec_t v;
      string t;
      v = vq[n];
      t = $sformatf("v%0d", n);
      step(v.rst, v.af, v.tv, v.wv, v.wa, v.clr);
      check({t, ".cnt0"}, 64'(almfull_cnt[3:0]), 64'(v.c0));
      check({t, ".cnt1"}, 64'(almfull_cnt[7:4]), 64'(v.c1));
      check({t, ".peak0"}, 64'(peak_cnt[3:0]), 64'(v.p0));
      check({t, ".peak1"}, 64'(peak_cnt[7:4]), 64'(v.p1));
      check({t, ".err_almfull"}, 64'(err_almfull), 64'(v.eaf));
      check({t, ".err_addr"}, 64'(err_addr), 64'(v.ea));
      check({t, ".err_any"}, 64'(err_any), 64'((|v.eaf) | v.ea));
      check({t, ".first_valid"}, 64'(first_err_valid), 64'(v.fv));
      check({t, ".viol_total"}, 64'(viol_total), 64'(v.viol));
      if (v.chk_cap) begin
        check({t, ".first_code"}, 64'(first_err_code), 64'(v.code));
        check({t, ".bad_addr"}, 64'(bad_addr), 64'(v.bad));
      end
    end

    // Saturation of count and viol_total with CNT_W=4 (count 10, viol 6 going in)
    for (int k = 1; k <= 10; k++) begin
      int ec, ev;
      ec = (10 + k > 15) ? 15 : 10 + k;
      ev = (6 + k > 15) ? 15 : 6 + k;
      step(0, 2'b01, 2'b01, 0, 0, 0);
      check($sformatf("sat%0d.cnt0", k), 64'(almfull_cnt[3:0]), 64'(ec));
      check($sformatf("sat%0d.peak0", k), 64'(peak_cnt[3:0]), 64'(ec));
      check($sformatf("sat%0d.viol_total", k), 64'(viol_total), 64'(ev));
      check($sformatf("sat%0d.err_almfull", k), 64'(err_almfull), 64'(2'b01));
    end

    // Reset mid-burst with events present: everything clears, events ignored
    step(1, 2'b11, 2'b11, 1, 42'h0, 0);
    check("rst.cnt", 64'(almfull_cnt), 64'(0));
    check("rst.peak", 64'(peak_cnt), 64'(0));
    check("rst.err_almfull", 64'(err_almfull), 64'(0));
    check("rst.err_addr", 64'(err_addr), 64'(0));
    check("rst.err_any", 64'(err_any), 64'(0));
    check("rst.first_valid", 64'(first_err_valid), 64'(0));
    check("rst.first_code", 64'(first_err_code), 64'(0));
    check("rst.bad_addr", 64'(bad_addr), 64'(0));
    check("rst.viol_total", 64'(viol_total), 64'(0));

    // Counting restarts from zero on the first non-reset cycle
    step(0, 2'b01, 2'b01, 0, 0, 0);
    check("post.cnt0", 64'(almfull_cnt[3:0]), 64'(1));
    check("post.err_almfull", 64'(err_almfull), 64'(0));
    check("post.viol_total", 64'(viol_total), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ccip_tx_protocol_monitor.md
CCIP_TX_PROTOCOL_MONITOR -- requirements
Module: ccip_tx_protocol_monitor

Interface
REQ-001 Parameter N_CH, default 2: number of monitored TX channels, 1..8.
REQ-002 Parameter MAX_ALMFULL_PKTS, default 8: packets allowed per channel while its almost-full is asserted.
REQ-003 Parameter CNT_W, default 32: width of per-channel counters, at least 4.
REQ-004 Parameter ADDR_W, default 42: width of the monitored write address.
REQ-005 Parameter ADDR_FLOOR, default 'h100: write addresses less than or equal to this are illegal.
REQ-006 Port pClk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 Port pck_cp2af_softReset, input, 1: synchronous, active-high reset.
REQ-008 Port almfull, input, N_CH: per-channel almost-full from the platform.
REQ-009 Port tx_valid, input, N_CH: per-channel packet-issue strobe.
REQ-010 Port wr_valid, input, 1: write-channel packet valid.
REQ-011 Port wr_addr, input, ADDR_W: address of the write-channel packet.
REQ-012 Port clear_errs, input, 1: clears sticky error state and peaks.
REQ-013 Port almfull_cnt, output, N_CH*CNT_W: live per-channel counts; channel i is in bits [i*CNT_W +: CNT_W].
REQ-014 Port peak_cnt, output, N_CH*CNT_W: per-channel maximum almfull_cnt since reset or clear, packed the same way.
REQ-015 Port err_almfull, output, N_CH: sticky per-channel overrun flags.
REQ-016 Port err_addr, output, 1: sticky low-address flag.
REQ-017 Port err_any, output, 1: OR of all sticky flags.
REQ-018 Port first_err_valid, output, 1: a first error has been captured.
REQ-019 Port first_err_code, output, 4: code of the first error; channel i gives i, the address error gives 4'hF.
REQ-020 Port bad_addr, output, ADDR_W: wr_addr of the first low-address violation.
REQ-021 Port viol_total, output, CNT_W: saturating count of all violation events.

Function
REQ-022 Per channel i, in each cycle:
- almfull[i]=0: the count is loaded with 0.
- almfull[i]=1 and tx_valid[i]=1: the count increments, saturating at all-ones.
- almfull[i]=1 and tx_valid[i]=0: the count holds.
REQ-023 An overrun event on channel i occurs in a cycle with almfull[i]=1, tx_valid[i]=1 and count_i >= MAX_ALMFULL_PKTS (pre-increment value), i.e. on the (MAX+1)th packet.
- A valid in the same cycle that almfull rises counts as packet 1.
REQ-024 An address event occurs in a cycle with wr_valid=1 and wr_addr <= ADDR_FLOOR (unsigned compare).
REQ-025 Every flag, count, peak and capture updates on the edge following the causing input: 1-cycle latency, no combinational input-to-output path.
REQ-026 Sticky flags set on an event and clear only on reset or clear_errs.
- If an event coincides with clear_errs, the event wins and the flag is set.
REQ-027 peak_cnt[i] is loaded with next count_i whenever that exceeds the current peak.
- clear_errs loads each peak with the current count_i, not 0.
REQ-028 first_err_valid/first_err_code/bad_addr are captured only while first_err_valid=0.
- When several events occur in the same cycle, the lowest channel index wins and the address error ranks last.
- bad_addr is captured only when the captured code is F.
- clear_errs rearms capture, and a same-cycle event is captured.
REQ-029 viol_total adds the number of events in the cycle (0..N_CH+1), saturating.
- viol_total is not affected by clear_errs.
REQ-030 err_any is registered and equals the OR of the next-state sticky flags.
REQ-031 clear_errs does not affect almfull_cnt.

Reset
REQ-032 While pck_cp2af_softReset=1, all outputs go to 0 on the next edge, and all events in that cycle are ignored.
REQ-033 Reset asserted mid-burst discards counts; counting restarts from 0 on the first non-reset cycle.

Verification
REQ-034 N_CH=2, almfull[0]=1, 8 valids -> cnt0=8, err_almfull=0; 9th valid -> err_almfull[0]=1, first_err_code=0, viol_total=1 one cycle later.
REQ-035 almfull[1] drops for 1 cycle between bursts of 5 and 5 -> cnt1 returns to 0 and no error; peak_cnt[1]=5.
REQ-036 wr_valid with wr_addr='h100 -> err_addr=1, bad_addr='h100, code F; wr_addr='h101 alone -> no error.
REQ-037 Overruns on channel 1 and channel 0 plus a bad address in the same cycle -> code 0, viol_total+=3, err_almfull=2'b11, err_addr=1.
REQ-038 clear_errs coincident with a 10th almfull valid on channel 0 -> err_almfull[0] stays 1, code recaptured as 0, peak_cnt[0]=10.
REQ-039 CNT_W=4, 20 valids under almfull -> cnt saturates at 15 and viol_total saturates at 15; reset pulse -> all outputs 0.
